// File: rtl/xnor_cla32_rr_scheduler_pkg.sv
// Shared constants, S1 payload type and round-robin pick helper for the
// shared-adder scheduler.
package cla_sched_pkg;

  localparam int unsigned ADD_W    = 32;
  localparam int unsigned SUM_W    = 33;
  localparam int unsigned MAX_REQ  = 8;
  localparam int unsigned ID_MAX_W = 3;

  // Operand-stage contents; id is sized for the largest legal requester count.
  typedef struct packed {
    logic [ADD_W-1:0]    a;
    logic [ADD_W-1:0]    b;
    logic [ID_MAX_W-1:0] id;
  } s1_payload_t;

  // One-hot grant: first valid index scanning ptr, ptr+1, ... modulo n.
  function automatic logic [MAX_REQ-1:0] rr_pick(
    input logic [MAX_REQ-1:0]  valid,
    input logic [ID_MAX_W-1:0] ptr,
    input int unsigned         n
  );
    logic [MAX_REQ-1:0] grant;
    logic               found;
    int unsigned        idx;
    grant = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < MAX_REQ; i++) begin
      idx = (32'(ptr) + i) % n;
      if ((i < n) && !found && valid[ID_MAX_W'(idx)]) begin
        grant[ID_MAX_W'(idx)] = 1'b1;
        found                 = 1'b1;
      end
    end
    return grant;
  endfunction

endpackage

// File: rtl/xnor_based_carry_lookahead_adder32.sv
// 32b + 32b -> 33b adder: xnor-derived propagate, 4-bit lookahead groups
// chained by group generate/propagate.
module xnor_based_carry_lookahead_adder32
  import cla_sched_pkg::*;
(
  input  logic [ADD_W-1:0] a_i,
  input  logic [ADD_W-1:0] b_i,
  output logic [SUM_W-1:0] result_o
);

  localparam int unsigned NGRP = ADD_W / 4;

  logic [ADD_W-1:0]     pn;
  logic [NGRP-1:0][3:0] p4;
  logic [NGRP-1:0][3:0] g4;
  logic [NGRP-1:0][3:0] c4;
  logic [3:0]           pk;
  logic [3:0]           gk;
  logic                 cin;

  assign pn = a_i ~^ b_i;
  assign p4 = ~pn;
  assign g4 = a_i & b_i;

  // Per-group lookahead; cin carries the group carry across iterations.
  always_comb begin
    c4  = '0;
    pk  = '0;
    gk  = '0;
    cin = 1'b0;
    for (int unsigned k = 0; k < NGRP; k++) begin
      pk = p4[3'(k)];
      gk = g4[3'(k)];
      c4[3'(k)] = {gk[2] | (pk[2] & gk[1]) | (pk[2] & pk[1] & gk[0]) | (pk[2] & pk[1] & pk[0] & cin),
                   gk[1] | (pk[1] & gk[0]) | (pk[1] & pk[0] & cin),
                   gk[0] | (pk[0] & cin),
                   cin};
      cin = gk[3] | (pk[3] & gk[2]) | (pk[3] & pk[2] & gk[1]) | (pk[3] & pk[2] & pk[1] & gk[0])
          | ((&pk) & cin);
    end
  end

  assign result_o = {cin, pn ~^ c4};

endmodule

// File: rtl/xnor_cla32_rr_scheduler_arbiter.sv
// Round-robin arbiter: one-hot grant, its index, and the pointer to use next.
module cla_rr_arbiter
  import cla_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic [ID_W-1:0]    ptr_i,
  input  logic               advance_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [ID_W-1:0]    grant_idx_o,
  output logic [ID_W-1:0]    ptr_nxt_o
);

  assign grant_o = NUM_REQ'(rr_pick(MAX_REQ'(valid_i), ID_MAX_W'(ptr_i), NUM_REQ));

  // Encode the one-hot grant to an index.
  always_comb begin
    grant_idx_o = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (grant_o[ID_W'(k)]) grant_idx_o = ID_W'(k);
    end
  end

  // Pointer moves just past the granted requester only on a transfer.
  always_comb begin
    ptr_nxt_o = ptr_i;
    if (advance_i) begin
      ptr_nxt_o = (grant_idx_o == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx_o + ID_W'(1);
    end
  end

endmodule

// File: rtl/xnor_cla32_rr_scheduler.sv
// Shares one adder among NUM_REQ requesters: round-robin arbitration,
// S1 operand register, adder, S2 result register driving the response port.
module xnor_cla32_rr_scheduler
  import cla_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NUM_REQ-1:0]       req_valid_i,
  output logic [NUM_REQ-1:0]       req_ready_o,
  input  logic [NUM_REQ*ADD_W-1:0] req_a_i,
  input  logic [NUM_REQ*ADD_W-1:0] req_b_i,
  output logic                     rsp_valid_o,
  input  logic                     rsp_ready_i,
  output logic [SUM_W-1:0]         rsp_sum_o,
  output logic [ID_W-1:0]          rsp_id_o
);

  logic [ADD_W-1:0]    a_arr [NUM_REQ];
  logic [ADD_W-1:0]    b_arr [NUM_REQ];
  logic [NUM_REQ-1:0]  grant;
  logic [ID_W-1:0]     grant_idx;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic                s1_vld_q, s2_vld_q;
  logic                s2_adv, s1_en, req_xfer;
  s1_payload_t         s1_q, s1_d;
  logic [SUM_W-1:0]    adder_sum, s2_sum_q;
  logic [ID_MAX_W-1:0] s2_id_q;

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
    assign a_arr[k] = req_a_i[ADD_W*k +: ADD_W];
    assign b_arr[k] = req_b_i[ADD_W*k +: ADD_W];
  end

  assign s2_adv      = s1_vld_q & (~s2_vld_q | rsp_ready_i);
  assign s1_en       = ~s1_vld_q | s2_adv;
  assign req_ready_o = rst_i ? '0 : (grant & {NUM_REQ{s1_en}});
  assign req_xfer    = |req_ready_o;

  cla_rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .valid_i     (req_valid_i),
    .ptr_i       (rr_ptr_q),
    .advance_i   (req_xfer),
    .grant_o     (grant),
    .grant_idx_o (grant_idx),
    .ptr_nxt_o   (rr_ptr_d)
  );

  // Select the granted requester's operands for S1.
  always_comb begin
    s1_d.a  = a_arr[grant_idx];
    s1_d.b  = b_arr[grant_idx];
    s1_d.id = ID_MAX_W'(grant_idx);
  end

  xnor_based_carry_lookahead_adder32 u_add (
    .a_i      (s1_q.a),
    .b_i      (s1_q.b),
    .result_o (adder_sum)
  );

  // S1 and the round-robin pointer: load on accept, bubble when nothing is granted.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_vld_q <= 1'b0;
      s1_q     <= '0;
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      if (s1_en) begin
        s1_vld_q <= req_xfer;
        if (req_xfer) s1_q <= s1_d;
      end
    end
  end

  // S2: frozen while a response is stalled; data holds across bubbles.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s2_vld_q <= 1'b0;
      s2_sum_q <= '0;
      s2_id_q  <= '0;
    end else begin
      if (~s2_vld_q | rsp_ready_i) s2_vld_q <= s1_vld_q;
      if (s2_adv) begin
        s2_sum_q <= adder_sum;
        s2_id_q  <= s1_q.id;
      end
    end
  end

  assign rsp_valid_o = s2_vld_q;
  assign rsp_sum_o   = s2_sum_q;
  assign rsp_id_o    = ID_W'(s2_id_q);

endmodule

// File: tb/tb_xnor_cla32_rr_scheduler.sv
// Directed bench for xnor_cla32_rr_scheduler with a golden adder instance.
module tb_xnor_cla32_rr_scheduler;

  localparam int unsigned N = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*32-1:0] req_a, req_b;
  logic            rsp_valid, rsp_ready;
  logic [32:0]     rsp_sum;
  logic [1:0]      rsp_id;
  logic [31:0]     gold_a, gold_b;
  logic [32:0]     gold_sum;

  int nvec  = 0;
  int nfail = 0;

  logic [31:0] opa [21];
  logic [31:0] opb [21];
  logic [32:0] gs  [21];
  int          nxt [4];

  int t_valid [19] = '{15, 15, 15, 15, 15, 14, 12, 8, 0, 15, 14, 14, 14, 14, 14, 12, 8, 0, 0};
  int t_rrdy  [19] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1};
  int t_ready [19] = '{1, 2, 4, 8, 1, 2, 4, 8, 0, 1, 0, 0, 0, 0, 2, 4, 8, 0, 0};
  int t_seq   [19] = '{-1, 0, 1, 2, 3, 4, 5, 6, 7, 7, 7, 7, 7, 7, 8, 9, 10, 11, -1};

  always #5 clk = ~clk;

  xnor_cla32_rr_scheduler #(.NUM_REQ(4), .ID_W(2)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_a_i     (req_a),
    .req_b_i     (req_b),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_sum_o   (rsp_sum),
    .rsp_id_o    (rsp_id)
  );

  xnor_based_carry_lookahead_adder32 u_gold (
    .a_i      (gold_a),
    .b_i      (gold_b),
    .result_o (gold_sum)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rsp(input string tag, input logic ev, input int eid, input int idx);
    chk({tag, " valid"}, 64'(rsp_valid), 64'(ev));
    if (ev) begin
      chk({tag, " id"}, 64'(rsp_id), 64'(eid));
      chk({tag, " sum"}, 64'(rsp_sum), 64'(gs[idx]));
    end
  endtask

  task automatic set_op(input int k, input int i);
    req_a[32*k +: 32] = opa[i];
    req_b[32*k +: 32] = opb[i];
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] tr;
    rst       = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    gold_a    = '0;
    gold_b    = '0;
    for (int i = 0; i < 21; i++) begin
      opa[i] = 32'h9E37_79B9 * 32'(i + 1);
      opb[i] = 32'hC2B2_AE35 * 32'(i + 3);
    end
    opa[19] = 32'h29AF_2430; opb[19] = 32'h7A1B_9ABC;
    opa[20] = 32'h0000_0000; opb[20] = 32'h1234_5678;
    for (int i = 0; i < 21; i++) begin
      gold_a = opa[i];
      gold_b = opb[i];
      #1;
      gs[i] = gold_sum;
    end

    // Reset state, with requests pending
    req_valid = 4'b1111;
    cyc;
    chk("rst valid", 64'(rsp_valid), 64'd0);
    chk("rst sum", 64'(rsp_sum), 64'd0);
    chk("rst id", 64'(rsp_id), 64'd0);
    chk("rst ready", 64'(req_ready), 64'd0);
    rst       = 1'b0;
    req_valid = '0;

    // 1: single request from req0, two-cycle latency
    req_valid = 4'b0001;
    set_op(0, 19);
    #1 chk("t1 ready", 64'(req_ready), 64'h1);
    cyc;
    req_valid = '0;
    chk_rsp("t1 n+1", 1'b0, 0, 0);
    cyc;
    chk_rsp("t1 n+2", 1'b1, 0, 19);
    cyc;
    chk_rsp("t1 drain", 1'b0, 0, 0);

    rst = 1'b1;
    cyc;
    rst = 1'b0;

    // 2+3: full load round robin, then 5-cycle stall and release
    for (int k = 0; k < 4; k++) nxt[k] = k;
    for (int c = 0; c < 19; c++) begin
      req_valid = 4'(t_valid[c]);
      rsp_ready = t_rrdy[c][0];
      for (int k = 0; k < 4; k++) set_op(k, nxt[k]);
      #1 chk("t23 ready", 64'(req_ready), 64'(t_ready[c]));
      tr = 4'(t_ready[c]);
      for (int k = 0; k < 4; k++) if (tr[k]) nxt[k] += 4;
      cyc;
      chk_rsp("t23 rsp", t_seq[c] >= 0, t_seq[c] % 4, (t_seq[c] >= 0) ? t_seq[c] : 0);
    end

    // 4: only req2/req3, pointer at 3
    req_valid = 4'b0100;
    set_op(2, 12);
    #1 chk("t4 ready0", 64'(req_ready), 64'h4);
    cyc;
    chk_rsp("t4 r0", 1'b0, 0, 0);
    req_valid = 4'b1100;
    set_op(2, 13);
    set_op(3, 14);
    #1 chk("t4 ready1", 64'(req_ready), 64'h8);
    cyc;
    chk_rsp("t4 r1", 1'b1, 2, 12);
    req_valid = 4'b0100;
    #1 chk("t4 ready2", 64'(req_ready), 64'h4);
    cyc;
    chk_rsp("t4 r2", 1'b1, 3, 14);
    req_valid = '0;
    #1 chk("t4 ready3", 64'(req_ready), 64'h0);
    cyc;
    chk_rsp("t4 r3", 1'b1, 2, 13);
    cyc;
    chk_rsp("t4 r4", 1'b0, 0, 0);

    // 5: reset with S1 and S2 both occupied
    req_valid = 4'b0011;
    set_op(0, 15);
    set_op(1, 16);
    #1 chk("t5 ready0", 64'(req_ready), 64'h1);
    cyc;
    req_valid = 4'b0010;
    #1 chk("t5 ready1", 64'(req_ready), 64'h2);
    cyc;
    chk_rsp("t5 pre", 1'b1, 0, 15);
    rsp_ready = 1'b0;
    req_valid = 4'b1100;
    set_op(2, 17);
    set_op(3, 18);
    #1 chk("t5 full ready", 64'(req_ready), 64'h0);
    #1 rst = 1'b1;
    #1;
    chk("t5 async valid", 64'(rsp_valid), 64'd0);
    chk("t5 async sum", 64'(rsp_sum), 64'd0);
    chk("t5 async id", 64'(rsp_id), 64'd0);
    chk("t5 async ready", 64'(req_ready), 64'd0);
    cyc;
    rst       = 1'b0;
    rsp_ready = 1'b1;
    #1 chk("t5 post ready0", 64'(req_ready), 64'h4);
    cyc;
    chk_rsp("t5 no stale", 1'b0, 0, 0);
    req_valid = 4'b1000;
    #1 chk("t5 post ready1", 64'(req_ready), 64'h8);
    cyc;
    chk_rsp("t5 p1", 1'b1, 2, 17);
    req_valid = '0;
    cyc;
    chk_rsp("t5 p2", 1'b1, 3, 18);
    cyc;
    chk_rsp("t5 p3", 1'b0, 0, 0);

    // 6: req1 a=0 with bubbles between requests
    for (int n = 0; n < 2; n++) begin
      req_valid = 4'b0010;
      set_op(1, 20);
      #1 chk("t6 ready", 64'(req_ready), 64'h2);
      cyc;
      chk_rsp("t6 bubble", 1'b0, 0, 0);
      req_valid = '0;
      #1 chk("t6 idle ready", 64'(req_ready), 64'h0);
      cyc;
      chk_rsp("t6 rsp", 1'b1, 1, 20);
      chk("t6 sum const", 64'(rsp_sum), 64'h0_1234_5678);
    end
    cyc;
    chk_rsp("t6 end", 1'b0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
